// File: rtl/gate_drive_guard.sv
// gate_drive_guard: shoot-through interlock, min-pulse filter, bootstrap
// precharge sequencing and latched fault shutdown for a three-phase bridge.
// Optional feature macro: GATE_GUARD_OVERLAP_CNT_EN (overlap cycle counter).
module gate_drive_guard #(
  parameter int unsigned MIN_PULSE_CYCLES    = 20,
  parameter int unsigned FAULT_FILTER_CYCLES = 10,
  parameter int unsigned PRECHARGE_CYCLES    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fault_n,
  input  logic        fault_clr,
  input  logic [5:0]  gate_in,
  output logic [5:0]  gate_out,
  output logic [1:0]  state,
  output logic        fault_latched,
  output logic [15:0] overlap_cnt
);

  localparam int unsigned NUM_SW  = 6;
  localparam int unsigned NUM_LEG = 3;
  localparam int unsigned MP_W    = 8;
  localparam int unsigned FLT_W   = 8;
  localparam int unsigned PRE_W   = 16;
  localparam logic [5:0]  LOW_SIDES_ON = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            cur_st, nxt_st;
  logic              flt_s1, flt_s2;
  logic [FLT_W-1:0]  filt_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [MP_W-1:0]   mp_cnt [NUM_SW];
  logic              trip_c, pre_done_c, keep_run_c;
  logic [NUM_LEG-1:0] ovl_c;
  logic [5:0]        masked_c, on_c, guarded_c, gate_d_c;

  assign state = cur_st;

  // Two-flop synchronizer of the active-high fault condition
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_s1 <= 1'b0;
      flt_s2 <= 1'b0;
    end else begin
      flt_s1 <= ~fault_n;
      flt_s2 <= flt_s1;
    end
  end

  // Fault debounce counter, saturates at the trip threshold
  always_ff @(posedge clk) begin
    if (rst || !flt_s2) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FLT_W'(FAULT_FILTER_CYCLES)) begin
      filt_cnt <= filt_cnt + FLT_W'(1);
    end
  end

  // Trip fires on the edge where the debounce count reaches the threshold
  assign trip_c     = flt_s2 && (filt_cnt >= FLT_W'(FAULT_FILTER_CYCLES - 1));
  assign pre_done_c = (pre_cnt == PRE_W'(PRECHARGE_CYCLES - 1));
  assign keep_run_c = (cur_st == ST_RUN) && (nxt_st == ST_RUN);

  // Precharge duration counter, restarts on any state change
  always_ff @(posedge clk) begin
    if (rst || cur_st != ST_PRE || nxt_st != cur_st) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) cur_st <= ST_IDLE;
    else     cur_st <= nxt_st;
  end

  // Next-state logic; a trip overrides every other transition
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE:  if (en && !flt_s2) nxt_st = ST_PRE;
      ST_PRE:   if (!en) nxt_st = ST_IDLE;
                else if (pre_done_c) nxt_st = ST_RUN;
      ST_RUN:   if (!en) nxt_st = ST_IDLE;
      ST_FAULT: if (fault_clr && !flt_s2 && !en) nxt_st = ST_IDLE;
      default:  nxt_st = ST_IDLE;
    endcase
    if (trip_c) nxt_st = ST_FAULT;
  end

  // Per-leg interlock mask, min-pulse qualification and final leg guard
  always_comb begin
    masked_c  = gate_in;
    ovl_c     = '0;
    on_c      = '0;
    guarded_c = '0;
    for (int l = 0; l < NUM_LEG; l++) begin
      ovl_c[l] = gate_in[2*l] & gate_in[2*l+1];
      if (ovl_c[l]) begin
        masked_c[2*l]   = 1'b0;
        masked_c[2*l+1] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_SW; i++) begin
      on_c[i] = masked_c[i] && (mp_cnt[i] == MP_W'(MIN_PULSE_CYCLES));
    end
    for (int l = 0; l < NUM_LEG; l++) begin
      if (!(on_c[2*l] && on_c[2*l+1])) begin
        guarded_c[2*l]   = on_c[2*l];
        guarded_c[2*l+1] = on_c[2*l+1];
      end
    end
    gate_d_c = '0;
    if (nxt_st == ST_PRE)  gate_d_c = LOW_SIDES_ON;
    else if (keep_run_c)   gate_d_c = guarded_c;
  end

  // Min-pulse counters, cleared outside a steady RUN stint or on a low input
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SW; i++) begin
      if (rst || !keep_run_c || !masked_c[i]) begin
        mp_cnt[i] <= '0;
      end else if (mp_cnt[i] != MP_W'(MIN_PULSE_CYCLES)) begin
        mp_cnt[i] <= mp_cnt[i] + MP_W'(1);
      end
    end
  end

  // Registered pin drive and fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_out      <= '0;
      fault_latched <= 1'b0;
    end else begin
      gate_out      <= gate_d_c;
      fault_latched <= (nxt_st == ST_FAULT);
    end
  end

`ifdef GATE_GUARD_OVERLAP_CNT_EN
  logic [1:0]  ovl_n_c;
  logic [16:0] ovl_sum_c;

  assign ovl_n_c   = 2'(ovl_c[0]) + 2'(ovl_c[1]) + 2'(ovl_c[2]);
  assign ovl_sum_c = {1'b0, overlap_cnt} + 17'(ovl_n_c);

  // Saturating count of overlapping legs per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overlap_cnt <= '0;
    end else if (cur_st == ST_RUN) begin
      overlap_cnt <= ovl_sum_c[16] ? 16'hFFFF : ovl_sum_c[15:0];
    end
  end
`else
  assign overlap_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_drive_guard.sv
// Self-checking bench for gate_drive_guard against an edge-level behavioural model.
module tb_gate_drive_guard;

  localparam int unsigned MP = 20;
  localparam int unsigned FF = 10;
  localparam int unsigned PC = 1000;

  logic        clk = 1'b0;
  logic        rst, en, fault_n, fault_clr;
  logic [5:0]  gate_in;
  logic [5:0]  gate_out;
  logic [1:0]  state;
  logic        fault_latched;
  logic [15:0] overlap_cnt;

  always #5 clk = ~clk;

  gate_drive_guard #(
    .MIN_PULSE_CYCLES(MP), .FAULT_FILTER_CYCLES(FF), .PRECHARGE_CYCLES(PC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fault_n(fault_n), .fault_clr(fault_clr),
    .gate_in(gate_in), .gate_out(gate_out), .state(state),
    .fault_latched(fault_latched), .overlap_cnt(overlap_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: fault delay line, streak lengths, precharge start edge
  int         m_state;
  logic [5:0] m_gate;
  int         m_ovl;
  bit         m_flat;
  bit         h1, h2;
  int         frun;
  int         streak [6];
  int         edge_n;
  int         p_start;

  task automatic model_edge();
    bit sync, trip, stay;
    int nxt, ovl_legs;
    logic [5:0] masked, on;
    edge_n++;
    if (rst) begin
      m_state = 0; m_gate = '0; m_ovl = 0; m_flat = 0;
      h1 = 0; h2 = 0; frun = 0;
      for (int i = 0; i < 6; i++) streak[i] = 0;
    end else begin
      sync = h2; h2 = h1; h1 = !fault_n;
      frun = sync ? frun + 1 : 0;
      trip = (frun >= int'(FF));
      nxt = m_state;
      case (m_state)
        0: if (en && !sync) nxt = 1;
        1: if (!en) nxt = 0; else if (edge_n - p_start == int'(PC)) nxt = 2;
        2: if (!en) nxt = 0;
        default: if (fault_clr && !sync && !en) nxt = 0;
      endcase
      if (trip) nxt = 3;
      masked = gate_in;
      ovl_legs = 0;
      for (int l = 0; l < 3; l++) begin
        if (gate_in[2*l] && gate_in[2*l+1]) begin
          masked[2*l] = 1'b0; masked[2*l+1] = 1'b0; ovl_legs++;
        end
      end
`ifdef GATE_GUARD_OVERLAP_CNT_EN
      if (m_state == 2) m_ovl = (m_ovl + ovl_legs > 65535) ? 65535 : m_ovl + ovl_legs;
`endif
      stay = (m_state == 2) && (nxt == 2);
      for (int i = 0; i < 6; i++) begin
        streak[i] = (stay && masked[i]) ? streak[i] + 1 : 0;
        on[i] = (streak[i] > int'(MP));
      end
      for (int l = 0; l < 3; l++)
        if (on[2*l] && on[2*l+1]) begin on[2*l] = 1'b0; on[2*l+1] = 1'b0; end
      m_gate = (nxt == 1) ? 6'b101010 : (stay ? on : 6'b000000);
      if (nxt == 1 && m_state != 1) p_start = edge_n;
      m_state = nxt;
      m_flat = (nxt == 3);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit fn, input bit clr, input logic [5:0] g);
    rst = r; en = e; fault_n = fn; fault_clr = clr; gate_in = g;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("gate_out", 32'(gate_out), 32'(m_gate));
    check("state", 32'(state), 32'(m_state));
    check("fault_latched", 32'(fault_latched), 32'(m_flat));
    check("overlap_cnt", 32'(overlap_cnt), 32'(m_ovl));
  endtask

  initial begin
    int n, len, fn_len;
    logic [5:0] g;
    m_state = 0; m_gate = '0; m_ovl = 0; m_flat = 0; h1 = 0; h2 = 0;
    frun = 0; edge_n = 0; p_start = 0;
    for (int i = 0; i < 6; i++) streak[i] = 0;
    rst = 1; en = 0; fault_n = 1; fault_clr = 0; gate_in = '0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 1, 0, 6'h00);
    cyc(1, 0, 1, 0, 6'h00);
    check("reset_state", 32'(state), 32'd0);

    // Precharge length and entry into RUN
    n = 0;
    for (int i = 0; i < 1010; i++) begin
      cyc(0, 1, 1, 0, 6'h00);
      if (gate_out == 6'b101010) n++;
      if (i == 999) check("pre_last_cycle", 32'(state), 32'd1);
      if (i == 1000) check("run_after_pre", 32'(state), 32'd2);
    end
    check("pre_len", 32'(n), 32'd1000);

    // Short pulse swallowed, long pulse trimmed by MP
    n = 0;
    for (int i = 0; i < 19; i++) begin cyc(0, 1, 1, 0, 6'h01); n += int'(gate_out[0]); end
    for (int i = 0; i < 10; i++) begin cyc(0, 1, 1, 0, 6'h00); n += int'(gate_out[0]); end
    check("pulse19_len", 32'(n), 32'd0);
    n = 0;
    for (int i = 0; i < 50; i++) begin cyc(0, 1, 1, 0, 6'h01); n += int'(gate_out[0]); end
    check("pulse50_last_high", 32'(gate_out[0]), 32'd1);
    cyc(0, 1, 1, 0, 6'h00);
    check("pulse50_fall", 32'(gate_out[0]), 32'd0);
    check("pulse50_len", 32'(n), 32'd30);

    // Leg A overlap masked and counted
    n = 0;
    for (int i = 0; i < 50; i++) begin cyc(0, 1, 1, 0, 6'h03); n += int'(gate_out[1:0] != 2'b00); end
    check("ovl_masked", 32'(n), 32'd0);
`ifdef GATE_GUARD_OVERLAP_CNT_EN
    check("ovl_cnt50", 32'(overlap_cnt), 32'd50);
`else
    check("ovl_cnt50", 32'(overlap_cnt), 32'd0);
`endif

    // Randomized segments of held gate patterns with short fault glitches
    n = 0;
    while (n < 2000) begin
      g = 6'($urandom);
      len = $urandom_range(1, 40);
      fn_len = (len >= 20 && $urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
      for (int j = 0; j < len; j++) cyc(0, 1, (j < fn_len) ? 1'b0 : 1'b1, 0, g);
      n += len;
    end

    // Reset mid-RUN with an output on
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 0, 6'h04);
    cyc(1, 1, 1, 0, 6'h04);
    check("rst_gate", 32'(gate_out), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ovl", 32'(overlap_cnt), 32'd0);

    // Back to RUN, then fault filter boundary
    for (int i = 0; i < 1005; i++) cyc(0, 1, 1, 0, 6'h10);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 6'h10);
    for (int i = 0; i < 15; i++) cyc(0, 1, 1, 0, 6'h10);
    check("no_trip9", 32'(state), 32'd2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 6'h10);
    cyc(0, 1, 1, 0, 6'h10);
    check("trip10_not_yet", 32'(state), 32'd2);
    cyc(0, 1, 1, 0, 6'h10);
    check("trip10_state", 32'(state), 32'd3);
    check("trip10_gate", 32'(gate_out), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 6'h00);
    cyc(0, 1, 1, 1, 6'h00);
    check("clr_with_en", 32'(state), 32'd3);
    cyc(0, 0, 1, 0, 6'h00);
    cyc(0, 0, 1, 1, 6'h00);
    check("clr_ok", 32'(state), 32'd0);
    cyc(0, 0, 1, 0, 6'h00);

    // Trip coinciding with precharge completion
    for (int i = 0; i < 1005; i++) begin
      cyc(0, 1, (i >= int'(PC) - int'(FF) - 1) ? 1'b0 : 1'b1, 0, 6'h00);
      if (i == int'(PC)) check("trip_vs_pre", 32'(state), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
